// File: rtl/fnd_scan_decoder.sv
// ---------------------------------------------------------------------------
// fnd_scan_decoder
//
// Reader side of a multiplexed common-anode 7-segment (FND) interface.
// Snoops the active-low segment and digit-select lines produced by a scan
// driver, recovers each digit's BCD value once the lines have been stable
// for STABLE_CYCLES samples, and publishes a complete frame of NUM_DIGITS
// digits atomically with a single-cycle frame_valid pulse.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical consecutive samples needed for a capture (>=1)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   segment lines, active-low, bit6=a ... bit0=g
//   an_n[N-1:0]  digit selects, active-low, bit0 = rightmost digit
//   bcd_out      recovered frame, nibble k = digit k (all F = blank)
//   frame_valid  one-cycle pulse when bcd_out is updated
//   pattern_err  one-cycle pulse when an undecodable pattern is captured
//   err_sticky   set with pattern_err, rewritten at each frame completion
//
// Optional build macro FND_DP_EN adds:
//   dp_n         active-low decimal point (synchronized, part of the
//                stability compare)
//   dp_out[N-1:0] per-digit decimal point, active-high, published with
//                bcd_out
// ---------------------------------------------------------------------------

module fnd_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    err_sticky
`ifdef FND_DP_EN
    ,
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // ST_IDLE  | no single digit selected (blank or ghost); counter = 0
    // ST_SETTLE| valid select seen, counting identical samples
    // ST_HOLD  | digit captured; waiting for the lines to change

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef FND_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                          state;
    logic   [CW-1:0]                 cnt;
    logic   [SW-1:0]                 pins_raw;
    logic   [SW-1:0]                 samp_s1;
    logic   [SW-1:0]                 samp_s2;
    logic   [SW-1:0]                 samp_prev;
    logic   [NUM_DIGITS-1:0]         an_s;
    logic   [6:0]                    seg_s;
    logic   [NUM_DIGITS-1:0][3:0]    shadow;
    logic   [NUM_DIGITS-1:0]         mask;
    logic                            err_acc;

    logic                            same;
    logic                            sel_valid;
    logic   [IW-1:0]                 sel_idx;
    logic   [3:0]                    seg_nib;
    logic                            seg_err;
    logic   [CW-1:0]                 cnt_plus;
    logic                            cap;
    logic                            frame_full;

`ifdef FND_DP_EN
    logic                            dp_s;
    logic   [NUM_DIGITS-1:0]         shadow_dp;

    assign pins_raw = {an_n, dp_n, seg_n};
    assign dp_s     = samp_s2[7];
`else
    assign pins_raw = {an_n, seg_n};
`endif

    assign an_s  = samp_s2[SW-1 -: NUM_DIGITS];
    assign seg_s = samp_s2[6:0];

    // Two-flop synchronizers plus one more stage that holds the previous
    // synchronized sample for the stability compare. Idle level is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_s1   <= '1;
            samp_s2   <= '1;
            samp_prev <= '1;
        end else begin
            samp_s1   <= pins_raw;
            samp_s2   <= samp_s1;
            samp_prev <= samp_s2;
        end
    end

    assign same       = (samp_s2 == samp_prev);
    assign frame_full = &mask;

    // Exactly one select low is a real digit; none or several is idle/ghost.
    assign sel_valid = $onehot(~an_s);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    always_comb begin
        seg_err = 1'b0;
        case (seg_s)
            7'b0000001: seg_nib = 4'h0;
            7'b1001111: seg_nib = 4'h1;
            7'b0010010: seg_nib = 4'h2;
            7'b0000110: seg_nib = 4'h3;
            7'b1001100: seg_nib = 4'h4;
            7'b0100100: seg_nib = 4'h5;
            7'b0100000: seg_nib = 4'h6;
            7'b0001111: seg_nib = 4'h7;
            7'b0000000: seg_nib = 4'h8;
            7'b0000100: seg_nib = 4'h9;
            7'b1111111: seg_nib = 4'hF;
            default: begin
                seg_nib = 4'hE;
                seg_err = 1'b1;
            end
        endcase
    end

    // Count value after this edge if the sample is a valid select: only an
    // unchanged sample while settling extends the run, anything else starts
    // a fresh run at 1. Saturates so it can never wrap.
    always_comb begin
        if (state == ST_SETTLE && same) begin
            cnt_plus = (cnt < CNT_DONE) ? cnt + CNT_ONE : cnt;
        end else begin
            cnt_plus = CNT_ONE;
        end
    end

    // A capture fires on the edge where the run reaches STABLE_CYCLES; an
    // unchanged sample in HOLD never recaptures.
    assign cap = sel_valid && (cnt_plus == CNT_DONE) &&
                 ((state != ST_HOLD) || !same);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            shadow      <= '1;
            mask        <= '0;
            err_acc     <= 1'b0;
            bcd_out     <= '1;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            err_sticky  <= 1'b0;
`ifdef FND_DP_EN
            shadow_dp   <= '0;
            dp_out      <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;

            // Publish first; a capture later in this block belongs to the
            // next frame and overrides the mask clear for its own bit.
            if (frame_full) begin
                bcd_out     <= shadow;
                frame_valid <= 1'b1;
                mask        <= '0;
                err_sticky  <= err_acc;
                err_acc     <= 1'b0;
`ifdef FND_DP_EN
                dp_out      <= shadow_dp;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cnt   <= cnt_plus;
                        state <= cap ? ST_HOLD : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!sel_valid) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_plus;
                        if (cap) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!same) begin
                        if (!sel_valid) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= cnt_plus;
                            state <= cap ? ST_HOLD : ST_SETTLE;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase

            if (cap) begin
                shadow[sel_idx] <= seg_nib;
                mask[sel_idx]   <= 1'b1;
`ifdef FND_DP_EN
                shadow_dp[sel_idx] <= ~dp_s;
`endif
                if (seg_err) begin
                    pattern_err <= 1'b1;
                    err_acc     <= 1'b1;
                    err_sticky  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fnd_scan_decoder.md
Name: fnd_scan_decoder

Overview:
Reader side of the multiplexed common-anode FND interface. The block snoops active-low segment lines and active-low digit-select lines driven by an FND scan driver, and recovers each digit's 4-bit BCD value. It assembles a full frame of NUM_DIGITS digits and publishes it atomically with a one-cycle valid pulse. It serves as a self-check monitor for FND counter designs and as a front-end for reading external 7-segment displays.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_n  input  7  segment lines, active-low, bit6=a, bit5=b, ... bit0=g
an_n  input  NUM_DIGITS  digit selects, active-low, bit0 = rightmost digit
bcd_out  output  4*NUM_DIGITS  recovered frame; nibble k = digit k
frame_valid  output  1  one-cycle pulse when bcd_out is updated
pattern_err  output  1  one-cycle pulse when a non-decodable pattern is captured
err_sticky  output  1  set with pattern_err; cleared by the next error-free frame

Behaviour:
- Reset (async, rst_n=0) clears: bcd_out=all 4'hF, frame_valid=0, pattern_err=0, err_sticky=0, sync flops=all 1s, stable counter=0, capture mask=0, shadow regs=4'hF, FSM=IDLE.
- Input sync: seg_n and an_n each pass through a 2-flop synchronizer; all logic below uses the synced values.
- Pattern map (seg_n -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->F (blank). Any other pattern -> E and counts as an error.
- Digit select is valid only when exactly one an_n bit is 0. All-ones or multiple zeros means idle/ghost: go to IDLE and clear the counter.
- FSM:
  - IDLE: wait for a valid select, then go to SETTLE with counter=1.
  - SETTLE: if {an_n,seg_n} equals the previous synced sample, counter++; else counter=1 and restart, or go to IDLE if the select is invalid. When counter reaches STABLE_CYCLES: write the decoded nibble to shadow[k], set mask[k], pulse pattern_err if the pattern maps to E, then go to HOLD.
  - HOLD: no recapture while {an_n,seg_n} is unchanged. Any change goes to SETTLE (counter=1) or IDLE.
- Recapturing the same digit before the frame completes overwrites shadow[k] (last value wins).
- Frame completion: on the cycle after mask becomes all ones, bcd_out<=shadow, frame_valid=1 for one cycle, and mask is cleared. err_sticky <= 1 if any capture in that frame errored, else 0.
- Latency: an input change on the pins produces a capture 2+STABLE_CYCLES cycles later; frame_valid follows 1 cycle after the final capture.
- Simultaneous events: a capture in the frame-completion cycle belongs to the next frame (mask is cleared, then the new bit is set). pattern_err and frame_valid may assert in the same cycle.
- The counter saturates at STABLE_CYCLES and never wraps.
- Reset mid-frame discards partial shadow contents. bcd_out returns to blank (all F).

Optional Feature:
FND_DP_EN: when defined, adds input dp_n (1 bit, active-low decimal point, synchronized and included in the stability compare) and output dp_out (NUM_DIGITS bits, active-high). It is captured per digit, published with bcd_out, and reset to 0. When undefined, neither port exists and behaviour is exactly as above.

Test Plan:
- Reset with rst_n=0 mid-run -> outputs go immediately to bcd_out=16'hFFFF, frame_valid=0, err_sticky=0.
- Scan digits 0..3 showing 1,2,3,4 (seg_n 1001111, 0010010, 0000110, 1001100), 10 cycles per digit -> one frame_valid with bcd_out=16'h4321 and pattern_err never asserted.
- Same scan held only 3 cycles per digit (STABLE_CYCLES=4) -> no capture and no frame_valid.
- Ghost select an_n=4'b1100 for 20 cycles between digits -> no capture; frame completes normally afterward.
- Digit 2 shows seg_n=1111110 -> pattern_err pulse at capture; frame bcd_out nibble2=E; err_sticky=1 until the next clean frame clears it.
- Continuous scan of 9,8,7,0 over 3 rotations -> 3 frame_valid pulses, each bcd_out=16'h0789, no duplicate capture while an_n is held.
